// File: rtl/regfile_wb_arbiter.sv
// Owns the register file write port, arbitrating ALU (src 0) vs mult/div (src 1) writebacks with
// starvation priority for src 1; tracks src-1 pending registers and flags decode hazards.
module regfile_wb_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [4:0]  req0_rd,
   input  logic [31:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [4:0]  req1_rd,
   input  logic [31:0] req1_data,
   output logic        req1_ready,
   output logic        wr_en,
   output logic [4:0]  wr_addr,
   output logic [31:0] wr_data,
   input  logic        set_valid,
   input  logic [4:0]  set_rd,
   output logic        set_ready,
   input  logic [4:0]  chk_rs,
   input  logic [4:0]  chk_rt,
   input  logic [4:0]  chk_rd,
   output logic        hazard
);

   logic [CNT_W-1:0] wait_cnt;
   logic [31:0]      busy;
   logic [31:0]      busy_nxt;
   logic             wr_src;
   logic             prio1;
   logic             grant0;
   logic             grant1;
   logic             set_ok;
   logic             hz_rs;
   logic             hz_rt;
   logic             hz_rd;

   assign prio1 = (wait_cnt >= CNT_W'(STARVE_LIMIT));

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (prio1 && req1_valid) begin
         grant1 = 1'b1;
      end else if (req0_valid) begin
         grant0 = 1'b1;
      end else if (req1_valid) begin
         grant1 = 1'b1;
      end
   end

   // Handshake outputs are held low for the whole reset window, not just after the first edge.
   assign req0_ready = rst_n && grant0;
   assign req1_ready = rst_n && grant1;

   assign set_ok    = (set_rd == 5'd0) || !busy[set_rd];
   assign set_ready = rst_n && set_valid && set_ok;

   // Second term: the register file still returns the old value during its write cycle.
   assign hz_rs  = (chk_rs != 5'd0) && (busy[chk_rs] || (wr_en && (wr_addr == chk_rs)));
   assign hz_rt  = (chk_rt != 5'd0) && (busy[chk_rt] || (wr_en && (wr_addr == chk_rt)));
   assign hz_rd  = (chk_rd != 5'd0) && (busy[chk_rd] || (wr_en && (wr_addr == chk_rd)));
   assign hazard = rst_n && (hz_rs || hz_rt || hz_rd);

   // Clear before set so a same-edge issue to the committing register leaves it busy.
   always_comb begin
      busy_nxt = busy;
      if (req1_ready && (req1_rd != 5'd0)) begin
         busy_nxt[req1_rd] = 1'b0;
      end
      if (set_ready && (set_rd != 5'd0)) begin
         busy_nxt[set_rd] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en    <= 1'b0;
         wr_addr  <= 5'd0;
         wr_data  <= 32'd0;
         wr_src   <= 1'b0;
         wait_cnt <= '0;
         busy     <= 32'd0;
      end else begin
         wr_en <= 1'b0;
         if (req0_ready) begin
            wr_en   <= (req0_rd != 5'd0);
            wr_addr <= req0_rd;
            wr_data <= req0_data;
            wr_src  <= 1'b0;
         end else if (req1_ready) begin
            wr_en   <= (req1_rd != 5'd0);
            wr_addr <= req1_rd;
            wr_data <= req1_data;
            wr_src  <= 1'b1;
         end

         if (req1_ready) begin
            wait_cnt <= '0;
         end else if (req1_valid && (wait_cnt != {CNT_W{1'b1}})) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end

         busy <= busy_nxt;
      end
   end

   a_wr_src_tracks_grant: assert property (@(posedge clk) disable iff (!rst_n)
      (req0_ready || req1_ready) |=> (wr_src == $past(req1_ready)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus a randomized run scored against a rule-level model of the arbiter.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid, set_valid;
   logic [4:0]  req0_rd, req1_rd, set_rd, chk_rs, chk_rt, chk_rd;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready, set_ready, hazard, wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .set_valid(set_valid), .set_rd(set_rd), .set_ready(set_ready),
      .chk_rs(chk_rs), .chk_rt(chk_rt), .chk_rd(chk_rd), .hazard(hazard)
   );

   task automatic idle();
      req0_valid = 1'b0; req0_rd = 5'd0; req0_data = 32'd0;
      req1_valid = 1'b0; req1_rd = 5'd0; req1_data = 32'd0;
      set_valid  = 1'b0; set_rd  = 5'd0;
      chk_rs = 5'd0; chk_rt = 5'd0; chk_rd = 5'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1; set_valid = 1'b1; set_rd = 5'd4;
      #12;
      n_checks++; if ({wr_en, wr_addr, wr_data} !== 38'd0) begin n_fail++; $display("FAIL reset_wr_port: got %b/%0d/%h want 0/0/0", wr_en, wr_addr, wr_data); end
      n_checks++; if ({req0_ready, req1_ready, set_ready, hazard} !== 4'b0000) begin n_fail++; $display("FAIL reset_comb_outs: got %b want 0000", {req0_ready, req1_ready, set_ready, hazard}); end
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      tick();
      n_checks++; if (dut.busy !== 32'd0 || dut.wait_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_state: got busy %h cnt %0d want 0 0", dut.busy, dut.wait_cnt); end
      // Mark r5 busy and start a write, then pull reset off-edge.
      set_valid = 1'b1; set_rd = 5'd5;
      req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h1234_5678;
      tick();
      idle();
      chk_rs = 5'd5;
      #1;
      n_checks++; if ({wr_en, hazard} !== 2'b11) begin n_fail++; $display("FAIL pre_reset_write: got wr_en,hazard %b want 11", {wr_en, hazard}); end
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (wr_en !== 1'b0 || dut.busy !== 32'd0) begin n_fail++; $display("FAIL async_reset: got wr_en %b busy %h want 0 0", wr_en, dut.busy); end
      n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL async_reset_hazard: got %b want 0", hazard); end
      rst_n = 1'b1;
      tick();
      n_checks++; if ({wr_en, hazard} !== 2'b00) begin n_fail++; $display("FAIL post_reset_clear: got %b want 00", {wr_en, hazard}); end
   endtask

   task automatic test_solo();
      idle();
      req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'hDEAD_BEEF;
      #1;
      n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL solo_ready: got %b want 10", {req0_ready, req1_ready}); end
      tick();
      idle();
      n_checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd3, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL solo_write: got %b/%0d/%h want 1/3/deadbeef", wr_en, wr_addr, wr_data); end
      req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 32'h0000_0055;
      #1;
      n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready: got %b want 1", req0_ready); end
      tick();
      idle();
      n_checks++; if ({wr_en, wr_addr, wr_data} !== {1'b0, 5'd0, 32'h55}) begin n_fail++; $display("FAIL r0_suppressed: got %b/%0d/%h want 0/0/55", wr_en, wr_addr, wr_data); end
      tick();
      n_checks++; if ({wr_en, wr_data} !== {1'b0, 32'h55}) begin n_fail++; $display("FAIL idle_hold: got %b/%h want 0/55", wr_en, wr_data); end
   endtask

   task automatic test_starvation();
      int exp_g[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      idle();
      req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'h2;
      tick();
      req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'h1;
      for (int i = 0; i < 10; i++) begin
         #1;
         n_checks++;
         if ({req0_ready, req1_ready} !== {exp_g[i] == 0, exp_g[i] == 1}) begin
            n_fail++; $display("FAIL grant_order[%0d]: got r0,r1 %b want src %0d", i, {req0_ready, req1_ready}, exp_g[i]);
         end
         tick();
         if (i == 4) begin
            n_checks++; if (dut.wait_cnt !== 4'd0) begin n_fail++; $display("FAIL starve_clear: got %0d want 0", dut.wait_cnt); end
         end
      end
      idle();
      tick();
   endtask

   task automatic test_scoreboard();
      idle();
      set_valid = 1'b1; set_rd = 5'd7;
      #1;
      n_checks++; if (set_ready !== 1'b1) begin n_fail++; $display("FAIL set7_ready: got %b want 1", set_ready); end
      tick();
      idle();
      chk_rs = 5'd7;
      set_valid = 1'b1; set_rd = 5'd7;
      #1;
      n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL busy7_hazard: got %b want 1", hazard); end
      n_checks++; if (set_ready !== 1'b0) begin n_fail++; $display("FAIL reissue7_blocked: got %b want 0", set_ready); end
      set_valid = 1'b0;
      req1_valid = 1'b1; req1_rd = 5'd7; req1_data = 32'h7777;
      #1;
      n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL r1_ready: got %b want 1", req1_ready); end
      tick();
      req1_valid = 1'b0;
      #1;
      n_checks++; if ({wr_en, wr_addr, hazard} !== {1'b1, 5'd7, 1'b1}) begin n_fail++; $display("FAIL write7_hazard: got %b/%0d/%b want 1/7/1", wr_en, wr_addr, hazard); end
      tick();
      n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL after7_hazard: got %b want 0", hazard); end
   endtask

   task automatic test_set_clear();
      idle();
      set_valid = 1'b1; set_rd = 5'd9;
      req1_valid = 1'b1; req1_rd = 5'd9; req1_data = 32'h9;
      #1;
      n_checks++; if ({set_ready, req1_ready} !== 2'b11) begin n_fail++; $display("FAIL same_edge_ready: got %b want 11", {set_ready, req1_ready}); end
      tick();
      idle();
      chk_rt = 5'd9;
      tick();
      n_checks++; if ({dut.busy[9], hazard} !== 2'b11) begin n_fail++; $display("FAIL set_wins: got busy9,hazard %b want 11", {dut.busy[9], hazard}); end
      req1_valid = 1'b1; req1_rd = 5'd9;
      tick();
      idle();
      tick();
   endtask

   task automatic test_zero();
      logic [31:0] busy_before;
      idle();
      set_valid = 1'b1; set_rd = 5'd0;
      #1;
      n_checks++; if (set_ready !== 1'b1) begin n_fail++; $display("FAIL set0_ready: got %b want 1", set_ready); end
      busy_before = dut.busy;
      req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 32'hFFFF_FFFF;
      tick();
      idle();
      #1;
      n_checks++; if (dut.busy !== busy_before || dut.busy[0] !== 1'b0) begin n_fail++; $display("FAIL set0_busy: got %h want %h", dut.busy, busy_before); end
      n_checks++; if ({wr_en, wr_addr, hazard} !== 8'd0) begin n_fail++; $display("FAIL zero_hazard: got %b/%0d/%b want 0/0/0", wr_en, wr_addr, hazard); end
   endtask

   task automatic test_random();
      bit          m_busy[32];
      int          m_refused;
      bit          m_wr_en;
      logic [4:0]  m_addr;
      logic [31:0] m_data;
      logic [4:0]  chk[3];
      bit          e_r0, e_r1, e_set, e_hz;
      idle();
      #2 rst_n = 1'b0;
      #3 rst_n = 1'b1;
      tick();
      foreach (m_busy[k]) m_busy[k] = 1'b0;
      m_refused = 0; m_wr_en = 1'b0; m_addr = 5'd0; m_data = 32'd0;
      for (int c = 0; c < 500; c++) begin
         req0_valid = ($urandom_range(0, 1) == 1);
         req1_valid = ($urandom_range(0, 1) == 1);
         set_valid  = ($urandom_range(0, 2) == 0);
         req0_rd = 5'($urandom_range(0, 7)); req1_rd = 5'($urandom_range(0, 7));
         set_rd  = 5'($urandom_range(0, 7));
         req0_data = $urandom; req1_data = $urandom;
         chk_rs = 5'($urandom_range(0, 7)); chk_rt = 5'($urandom_range(0, 7)); chk_rd = 5'($urandom_range(0, 7));
         #1;
         e_r1 = req1_valid && (m_refused >= 4 || !req0_valid);
         e_r0 = req0_valid && !e_r1;
         e_set = set_valid && (set_rd == 0 || !m_busy[set_rd]);
         chk[0] = chk_rs; chk[1] = chk_rt; chk[2] = chk_rd;
         e_hz = 1'b0;
         for (int k = 0; k < 3; k++)
            if (chk[k] != 0 && (m_busy[chk[k]] || (m_wr_en && m_addr == chk[k]))) e_hz = 1'b1;
         n_checks++;
         if ({req0_ready, req1_ready, set_ready, hazard, wr_en, wr_addr, wr_data} !==
             {e_r0, e_r1, e_set, e_hz, m_wr_en, m_addr, m_data}) begin
            n_fail++;
            $display("FAIL random[%0d]: got rdy %b%b%b hz %b wr %b/%0d/%h want rdy %b%b%b hz %b wr %b/%0d/%h", c,
                     req0_ready, req1_ready, set_ready, hazard, wr_en, wr_addr, wr_data,
                     e_r0, e_r1, e_set, e_hz, m_wr_en, m_addr, m_data);
         end
         m_wr_en = 1'b0;
         if (e_r0) begin m_wr_en = (req0_rd != 0); m_addr = req0_rd; m_data = req0_data; end
         if (e_r1) begin m_wr_en = (req1_rd != 0); m_addr = req1_rd; m_data = req1_data; end
         if (e_r1) m_refused = 0;
         else if (req1_valid && m_refused < 15) m_refused++;
         if (e_r1) m_busy[req1_rd] = 1'b0;
         if (e_set) m_busy[set_rd] = 1'b1;
         m_busy[0] = 1'b0;
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_solo();
      test_starvation();
      test_scoreboard();
      test_set_clear();
      test_zero();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file (write enable, 5-bit destination, 32-bit data; written on posedge clk; register 0 hard-wired to zero).
- Arbitrates that port between two writeback sources:
  - source 0: main ALU/load pipe.
  - source 1: long-latency mult/div unit.
- Keeps a 32-bit busy scoreboard of registers awaiting a source-1 result.
- Raises a decode-stage hazard for reads or writes of a busy or in-flight register.

Parameters:
- STARVE_LIMIT, 4: number of consecutive cycles source 1 may be refused before it gains priority. Legal range 1..15.
- CNT_W, 4: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  source 0 has a writeback.
- req0_rd  in  5  source 0 destination register.
- req0_data  in  32  source 0 write data.
- req0_ready  out  1  source 0 accepted this cycle.
- req1_valid  in  1  source 1 has a writeback.
- req1_rd  in  5  source 1 destination register.
- req1_data  in  32  source 1 write data.
- req1_ready  out  1  source 1 accepted this cycle.
- wr_en  out  1  register file write enable.
- wr_addr  out  5  register file write address.
- wr_data  out  32  register file write data.
- set_valid  in  1  decode issues a source-1 op targeting set_rd.
- set_rd  in  5  register to mark busy.
- set_ready  out  1  issue allowed.
- chk_rs  in  5  decode read register 1.
- chk_rt  in  5  decode read register 2.
- chk_rd  in  5  decode destination register.
- hazard  out  1  decode must stall.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_en=0, wr_addr=0, wr_data=0.
  - busy=0, wait_cnt=0, wr_src=0.
  - All outputs are forced to 0 while rst_n is low, including ready, set_ready and hazard.
  - Deassertion takes effect at the next posedge.
  - A request pending at reset is dropped; the source must re-present it.
- Arbitration (combinational, one grant per cycle):
  - prio1 = (wait_cnt >= STARVE_LIMIT).
  - If prio1 and req1_valid: req1_ready=1, req0_ready=0.
  - Else if req0_valid: req0_ready=1.
  - Else if req1_valid: req1_ready=1.
  - Never both ready. ready never asserts without the matching valid.
- Accept = valid && ready at posedge.
- Write stage: on accept, the next cycle's registered outputs are wr_en = (rd != 0), wr_addr = rd, wr_data = data, and wr_src records the winning source.
  - Latency: accept edge to the register file write edge is 1 cycle.
  - With no accept, wr_en=0; wr_addr and wr_data hold their values.
- rd=0 writebacks are accepted but suppressed (wr_en=0), and never affect busy.
- Starvation counter:
  - wait_cnt increments, saturating at 2^CNT_W-1, in each cycle with req1_valid && !req1_ready.
  - It clears on a source-1 accept.
  - It holds when req1_valid=0.
- Scoreboard:
  - set_ready = set_valid && (set_rd==0 || !busy[set_rd]). A same-register reissue waits until the pending result commits.
  - On set accept with set_rd != 0: busy[set_rd] <= 1.
  - On a source-1 accept with req1_rd != 0: busy[req1_rd] <= 0.
  - Same edge, same index set and clear: busy ends 1.
  - busy[0] is always 0.
- Hazard (combinational from registered state), for each x in {chk_rs, chk_rt, chk_rd} with x != 0:
  - hazard = 1 if busy[x]=1, or if wr_en=1 and wr_addr = x.
  - The second term covers the register file returning the old value during the write cycle.
- Source 0 writebacks to a busy register are legal and are written. Ordering is decode's responsibility, enforced by hazard.

Test Plan:
1. Reset mid-write: wr_en=1, busy[5]=1, rst_n pulled low off-edge -> wr_en=0 and busy=0 immediately, without waiting for a clock edge.
2. Solo writes: req0 (rd=3, data=0xDEADBEEF) -> next cycle wr_en=1, wr_addr=3, wr_data=0xDEADBEEF. Then req0 with rd=0 -> req0_ready=1, wr_en stays 0.
3. Contention and starvation, STARVE_LIMIT=4, both valid continuously:
   - req0 is granted for 4 cycles.
   - req1 is granted in the 5th cycle and wait_cnt returns to 0.
   - Grant order over 10 cycles: 0,0,0,0,1,0,0,0,0,1.
4. Scoreboard and hazard:
   - set_rd=7 accepted -> busy[7]=1.
   - chk_rs=7 -> hazard=1; a second set_rd=7 gives set_ready=0.
   - req1 writes rd=7 -> hazard=1 during the wr_en cycle (wr_addr=7), hazard=0 on the following cycle.
5. Simultaneous set and clear of register 9 on the same edge -> busy[9]=1 afterwards.
6. Zero register: set_rd=0 -> set_ready=1 and busy unchanged. chk_rs=chk_rt=chk_rd=0 with wr_addr=0 -> hazard=0.
